// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Fetch-side PC owner; drives the instruction-memory handshake
//               and applies branch / jump / jump-register redirects.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic [31:0] ex_pc,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [15:0] br_offset,
    input  logic        jmp_valid,
    input  logic [25:0] jmp_index,
    input  logic        jr_valid,
    input  logic [31:0] jr_target,
    output logic        addr_err
);

    localparam logic [1:0] S_BOOT    = 2'd0;
    localparam logic [1:0] S_FETCH   = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;
    localparam logic [1:0] S_ISSUE   = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [31:0] r_pc;
    logic [31:0] w_next_pc;
    logic        w_capture;
    logic        w_imem_req;

    logic [31:0] r_req_addr;
    logic        r_instr_valid;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic        r_addr_err;

    logic [31:0] w_seq;
    logic [31:0] w_br_tgt;
    logic [31:0] w_jmp_tgt;
    logic [31:0] w_jr_tgt;
    logic [31:0] w_target;
    logic        w_redir;

    assign w_seq     = ex_pc + 32'd4;
    assign w_br_tgt  = w_seq + {{14{br_offset[15]}}, br_offset, 2'b00};
    assign w_jmp_tgt = {w_seq[31:28], jmp_index, 2'b00};
    assign w_jr_tgt  = {jr_target[31:2], 2'b00};
    assign w_redir   = jr_valid | jmp_valid | (br_valid & br_taken);

    // jr wins over jmp, jmp over branch
    always_comb begin
        w_target = w_br_tgt;
        if (jr_valid) begin
            w_target = w_jr_tgt;
        end else if (jmp_valid) begin
            w_target = w_jmp_tgt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_capture    = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_next_state = S_FETCH;
                if (w_redir) begin
                    w_next_pc = w_target;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    if (w_redir) begin
                        w_next_pc = w_target;
                    end else begin
                        w_capture    = 1'b1;
                        w_next_state = S_ISSUE;
                    end
                end else if (w_redir) begin
                    w_next_pc    = w_target;
                    w_next_state = S_DISCARD;
                end
            end
            S_DISCARD: begin
                if (w_redir) begin
                    w_next_pc = w_target;
                end
                if (imem_ack) begin
                    w_next_state = S_FETCH;
                end
            end
            S_ISSUE: begin
                if (w_redir) begin
                    w_next_pc    = w_target;
                    w_next_state = S_FETCH;
                end else if (instr_ready) begin
                    w_next_pc    = r_pc + 32'd4;
                    w_next_state = S_FETCH;
                end
            end
            default: begin
                w_next_state = S_BOOT;
            end
        endcase
    end

    always_comb begin
        w_imem_req = 1'b0;
        if ((r_state == S_FETCH) || (r_state == S_DISCARD)) begin
            w_imem_req = 1'b1;
        end
    end

    // req_addr only moves when a fresh request begins, so an outstanding
    // request keeps its address even after pc has been redirected.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_req_addr    <= RESET_PC;
            r_instr_valid <= 1'b0;
            r_instr       <= 32'd0;
            r_instr_pc    <= 32'd0;
            r_addr_err    <= 1'b0;
        end else begin
            if (w_next_state == S_FETCH) begin
                r_req_addr <= w_next_pc;
            end
            r_instr_valid <= (w_next_state == S_ISSUE);
            if (w_capture) begin
                r_instr    <= imem_rdata;
                r_instr_pc <= r_pc;
            end
            r_addr_err <= jr_valid & (jr_target[1:0] != 2'b00);
        end
    end

    assign imem_req    = w_imem_req;
    assign imem_addr   = r_req_addr;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign addr_err    = r_addr_err;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Directed and randomized checks of pc_sequencer against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;
    logic [31:0] ex_pc = 32'd0;
    logic        br_valid = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] br_offset = 16'd0;
    logic        jmp_valid = 1'b0;
    logic [25:0] jmp_index = 26'd0;
    logic        jr_valid = 1'b0;
    logic [31:0] jr_target = 32'd0;
    logic        addr_err;

    int n_vec = 0;
    int n_err = 0;

    // Model: a request is either live or stale; an instruction is either held or not.
    bit          m_boot;
    bit          m_req;
    bit          m_stale;
    bit          m_valid;
    bit          m_err;
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    logic [31:0] m_instr;
    logic [31:0] m_ipc;

    pc_sequencer #(.RESET_PC(C_RESET_PC)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .ex_pc       (ex_pc),
        .br_valid    (br_valid),
        .br_taken    (br_taken),
        .br_offset   (br_offset),
        .jmp_valid   (jmp_valid),
        .jmp_index   (jmp_index),
        .jr_valid    (jr_valid),
        .jr_target   (jr_target),
        .addr_err    (addr_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_boot  = 1'b1;
        m_req   = 1'b0;
        m_stale = 1'b0;
        m_valid = 1'b0;
        m_err   = 1'b0;
        m_pc    = C_RESET_PC;
        m_addr  = C_RESET_PC;
        m_instr = 32'd0;
        m_ipc   = 32'd0;
    endtask

    function automatic logic [31:0] ref_target();
        logic signed [31:0] off;
        off = $signed(br_offset);
        if (jr_valid) return jr_target & ~32'h3;
        if (jmp_valid) return ((ex_pc + 32'd4) & 32'hF000_0000) | ({6'd0, jmp_index} * 32'd4);
        return ex_pc + 32'd4 + off * 4;
    endfunction

    task automatic model_update();
        bit          redir;
        logic [31:0] tgt;
        if (!reset_n) begin
            model_reset();
            return;
        end
        redir = jr_valid || jmp_valid || (br_valid && br_taken);
        tgt   = ref_target();
        m_err = jr_valid && (jr_target % 4 != 0);
        if (m_boot) begin
            m_boot = 1'b0;
            if (redir) m_pc = tgt;
            m_req  = 1'b1;
            m_addr = m_pc;
        end else if (m_req && !m_stale) begin
            if (imem_ack) begin
                if (redir) begin
                    m_pc   = tgt;
                    m_addr = tgt;
                end else begin
                    m_instr = imem_rdata;
                    m_ipc   = m_pc;
                    m_valid = 1'b1;
                    m_req   = 1'b0;
                end
            end else if (redir) begin
                m_pc    = tgt;
                m_stale = 1'b1;
            end
        end else if (m_req) begin
            if (redir) m_pc = tgt;
            if (imem_ack) begin
                m_stale = 1'b0;
                m_addr  = m_pc;
            end
        end else if (m_valid) begin
            if (redir || instr_ready) begin
                m_pc    = redir ? tgt : m_pc + 32'd4;
                m_valid = 1'b0;
                m_req   = 1'b1;
                m_addr  = m_pc;
            end
        end
    endtask

    task automatic check_all();
        chk("imem_req", imem_req, m_req);
        chk("imem_addr", imem_addr, m_addr);
        chk("instr_valid", instr_valid, m_valid);
        chk("instr", instr, m_instr);
        chk("instr_pc", instr_pc, m_ipc);
        chk("addr_err", addr_err, m_err);
    endtask

    task automatic step();
        model_update();
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic clear_redir();
        br_valid  = 1'b0;
        br_taken  = 1'b0;
        jmp_valid = 1'b0;
        jr_valid  = 1'b0;
    endtask

    task automatic run_until_valid();
        for (int i = 0; i < 20; i++) begin
            if (instr_valid) break;
            imem_ack   = imem_req;
            imem_rdata = $urandom;
            step();
        end
        imem_ack = 1'b0;
        chk("issue_timeout", instr_valid, 1'b1);
    endtask

    initial begin
        logic [31:0] saved_instr;
        logic [31:0] saved_pc;
        model_reset();
        #12;
        check_all();
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Back-to-back sequential fetch with one wait cycle per request
        instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 5 && !imem_req; i++) step();
            chk("seq_addr", imem_addr, 32'(k * 4));
            step();
            imem_ack   = 1'b1;
            imem_rdata = $urandom;
            step();
            imem_ack = 1'b0;
            chk("seq_instr", instr, imem_rdata);
            chk("seq_instr_pc", instr_pc, 32'(k * 4));
        end

        // Taken backward branch while issuing at 0x100
        instr_ready = 1'b0;
        jr_valid    = 1'b1;
        jr_target   = 32'h100;
        step();
        clear_redir();
        run_until_valid();
        chk("br_ipc", instr_pc, 32'h100);
        br_valid  = 1'b1;
        br_taken  = 1'b1;
        ex_pc     = 32'h100;
        br_offset = 16'hFFFC;
        step();
        clear_redir();
        chk("br_addr", imem_addr, 32'h0F4);
        chk("br_valid_drop", instr_valid, 1'b0);

        // Jump while a fetch at 0x20 waits three cycles for its ack
        run_until_valid();
        jr_valid  = 1'b1;
        jr_target = 32'h20;
        step();
        clear_redir();
        chk("jmp_pre_addr", imem_addr, 32'h20);
        jmp_valid = 1'b1;
        ex_pc     = 32'h1000_0010;
        jmp_index = 26'h40;
        step();
        clear_redir();
        for (int i = 0; i < 2; i++) begin
            chk("jmp_hold_addr", imem_addr, 32'h20);
            step();
        end
        imem_ack   = 1'b1;
        imem_rdata = $urandom;
        step();
        imem_ack = 1'b0;
        chk("jmp_new_addr", imem_addr, 32'h1000_0100);
        chk("jmp_dropped", instr_valid, 1'b0);

        // Misaligned jr beating a taken branch
        run_until_valid();
        jr_valid  = 1'b1;
        jr_target = 32'h203;
        br_valid  = 1'b1;
        br_taken  = 1'b1;
        ex_pc     = $urandom;
        br_offset = 16'($urandom);
        step();
        clear_redir();
        chk("jr_err", addr_err, 1'b1);
        chk("jr_addr", imem_addr, 32'h200);
        step();
        chk("jr_err_pulse", addr_err, 1'b0);

        // Decode back-pressure
        run_until_valid();
        saved_instr = instr;
        saved_pc    = instr_pc;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_instr", instr, saved_instr);
            chk("stall_ipc", instr_pc, saved_pc);
            chk("stall_req", imem_req, 1'b0);
        end
        instr_ready = 1'b1;
        step();
        chk("stall_next", imem_addr, saved_pc + 32'd4);

        // Reset while a request is outstanding, then a stray ack
        chk("pre_reset_req", imem_req, 1'b1);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        imem_ack   = 1'b1;
        imem_rdata = $urandom;
        step();
        step();
        reset_n = 1'b1;
        step();
        chk("rst_first_addr", imem_addr, C_RESET_PC);
        imem_ack = 1'b0;
        step();
        chk("rst_stray", instr_valid, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            imem_ack    = imem_req && ($urandom_range(0, 1) != 0);
            imem_rdata  = $urandom;
            ex_pc       = $urandom;
            br_offset   = 16'($urandom);
            jmp_index   = 26'($urandom);
            jr_target   = $urandom;
            br_valid    = ($urandom_range(0, 5) == 0);
            br_taken    = ($urandom_range(0, 1) != 0);
            jmp_valid   = ($urandom_range(0, 9) == 0);
            jr_valid    = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
